// File: rtl/fact_pkg.sv
// fact_pkg: controller/datapath select encodings shared by the factorial controller and datapath.
package fact_pkg;
  localparam logic [1:0] WA_HOLD = 2'b00;
  localparam logic [1:0] WA_DEC  = 2'b01;
  localparam logic [1:0] WA_LOAD = 2'b10;
  localparam logic [1:0] WB_INIT = 2'b00;
  localparam logic [1:0] WB_MUL  = 2'b01;
  localparam logic [1:0] WB_HOLD = 2'b10;
endpackage

// File: rtl/fact_mul.sv
// fact_mul: combinational ACC_W x N_W multiplier with full-width product.
module fact_mul #(
  parameter int ACC_W = 32,
  parameter int N_W   = 4
) (
  input  logic [ACC_W-1:0]     a,
  input  logic [N_W-1:0]       b,
  output logic [ACC_W+N_W-1:0] p
);
  assign p = {{N_W{1'b0}}, a} * {{ACC_W{1'b0}}, b};
endmodule

// File: rtl/fact_datapath.sv
// fact_datapath: factorial counter/accumulator datapath with a registered valid/ready result.
// Define FACT_OVF_EN to add the sticky ovf output.
module fact_datapath
  import fact_pkg::*;
#(
  parameter int N_W   = 4,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_W-1:0]   n_in,
  input  logic [1:0]       wa,
  input  logic [1:0]       wb,
  input  logic             done,
  output logic             z_out,
  output logic [ACC_W-1:0] res,
  output logic             res_valid,
`ifdef FACT_OVF_EN
  output logic             ovf,
`endif
  input  logic             res_ready
);
  logic [N_W-1:0]       cnt_q, cnt_d, m;
  logic [ACC_W-1:0]     acc_q, acc_d, res_q, res_d;
  logic                 done_q, res_valid_q, res_valid_d, cap;
  logic [ACC_W+N_W-1:0] prod;
  // cnt==0 multiplies by one so that 0! comes out as 1
  assign m     = (cnt_q == '0) ? N_W'(1) : cnt_q;
  assign z_out = cnt_q <= N_W'(1);
  fact_mul #(.ACC_W(ACC_W), .N_W(N_W)) u_mul (.a(acc_q), .b(m), .p(prod));
  always_comb begin
    cnt_d       = (wa == WA_LOAD) ? n_in :
                  (wa == WA_DEC)  ? ((cnt_q == '0) ? cnt_q : cnt_q - N_W'(1)) : cnt_q;
    acc_d       = (wb == WB_INIT) ? ACC_W'(1) :
                  (wb == WB_MUL)  ? prod[ACC_W-1:0] : acc_q;
    cap         = done & ~done_q;
    res_d       = cap ? acc_q : res_q;
    res_valid_d = cap | (res_valid_q & ~res_ready);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      acc_q       <= ACC_W'(1);
      done_q      <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      done_q      <= done;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
    end
  end
  assign res       = res_q;
  assign res_valid = res_valid_q;
`ifdef FACT_OVF_EN
  logic ovf_q, ovf_d;
  always_comb begin
    ovf_d = (wb == WB_INIT) ? 1'b0 :
            (wb == WB_MUL)  ? (ovf_q | (|prod[ACC_W+N_W-1:ACC_W])) : ovf_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`else
  logic prod_hi_unused;
  assign prod_hi_unused = |prod[ACC_W+N_W-1:ACC_W];
`endif
endmodule

// File: tb/tb_fact_datapath.sv
// tb_fact_datapath: bench acts as controller; expected results go to a queue checked by a monitor.
module tb_fact_datapath;
  import fact_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  n_in = '0;
  logic [1:0]  wa = WA_HOLD, wb = WB_HOLD;
  logic        done = 1'b0, res_ready = 1'b1;
  logic        z_out, res_valid;
  logic [31:0] res;
`ifdef FACT_OVF_EN
  logic        ovf;
`endif
  int total = 0, bad = 0;
  logic [31:0] exp_q[$];

  fact_datapath #(.N_W(4), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .n_in(n_in), .wa(wa), .wb(wb), .done(done),
    .z_out(z_out), .res(res), .res_valid(res_valid),
`ifdef FACT_OVF_EN
    .ovf(ovf),
`endif
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // load, then (n-1 or 1) multiply cycles; z_out checked against a down-counter model
  task automatic compute(input int n);
    int c, k;
    k = (n <= 1) ? 1 : n - 1;
    c = n;
    @(posedge clk); #1;
    n_in = 4'(n); wa = WA_LOAD; wb = WB_INIT;
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      check("z_out_step", 64'(z_out), 64'(c <= 1));
      wa = WA_DEC; wb = WB_MUL;
      c = (c == 0) ? 0 : c - 1;
    end
    @(posedge clk); #1;
    check("z_out_final", 64'(z_out), 64'(c <= 1));
    wa = WA_HOLD; wb = WB_HOLD;
  endtask

  task automatic finish_run(input logic [31:0] exp, input logic rdy);
    done = 1'b1; res_ready = rdy;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    done = 1'b0;
    check("res_valid_cap", 64'(res_valid), 64'd1);
    check("res_cap", 64'(res), 64'(exp));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL res_unexpected: got %0d expected none", res);
        end else check("res_pop", 64'(res), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_res", 64'(res), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_z", 64'(z_out), 64'd1);
`ifdef FACT_OVF_EN
    check("rst_ovf", 64'(ovf), 64'd0);
`endif
    @(posedge clk); #1; rst = 1'b1;
    compute(5);  finish_run(32'd120, 1'b1);
    compute(0);  finish_run(32'd1, 1'b1);
    compute(1);  finish_run(32'd1, 1'b1);
    compute(12); finish_run(32'd479001600, 1'b1);
    compute(13); finish_run(32'd1932053504, 1'b1);
`ifdef FACT_OVF_EN
    check("ovf_set", 64'(ovf), 64'd1);
`endif
    compute(3);  finish_run(32'd6, 1'b1);
`ifdef FACT_OVF_EN
    check("ovf_clear", 64'(ovf), 64'd0);
`endif
    // backpressure: result held five cycles, dropped the cycle after accept
    compute(4);  finish_run(32'd24, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(res_valid), 64'd1);
      check("hold_res", 64'(res), 64'd24);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("accept_drop", 64'(res_valid), 64'd0);
    // capture coinciding with accept
    res_ready = 1'b0;
    compute(2);  finish_run(32'd2, 1'b0);
    compute(3);
    check("held_during_run", 64'(res), 64'd2);
    finish_run(32'd6, 1'b1);
    @(posedge clk); #1;
    check("after_coincide_valid", 64'(res_valid), 64'd0);
    // reset mid-computation
    @(posedge clk); #1; n_in = 4'd7; wa = WA_LOAD; wb = WB_INIT;
    @(posedge clk); #1; wa = WA_DEC; wb = WB_MUL;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("midrst_res", 64'(res), 64'd0);
    check("midrst_valid", 64'(res_valid), 64'd0);
    check("midrst_z", 64'(z_out), 64'd1);
`ifdef FACT_OVF_EN
    check("midrst_ovf", 64'(ovf), 64'd0);
`endif
    wa = WA_HOLD; wb = WB_HOLD;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("postrst_valid", 64'(res_valid), 64'd0);
    end
    compute(6);  finish_run(32'd720, 1'b1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fact_datapath.md
FACT_DATAPATH -- requirements
Module: fact_datapath

Interface
REQ-001 SHALL have parameter N_W, default 4, the operand width of n_in.
REQ-002 SHALL have parameter ACC_W, default 32, the accumulator and result width.
REQ-003 SHALL have port clk, input, 1, the clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; asynchronous, active-low.
REQ-005 SHALL have port n_in, input, N_W, the factorial operand, sampled on load.
REQ-006 SHALL have port wa, input, 2, the counter-register select from the controller.
REQ-007 SHALL have port wb, input, 2, the accumulator select from the controller.
REQ-008 SHALL have port done, input, 1, the controller completion flag.
REQ-009 SHALL have port z_out, output, 1, the terminal-count flag to the controller.
REQ-010 SHALL have port res, output, ACC_W, the registered result.
REQ-011 SHALL have port res_valid, output, 1, high while res holds an unconsumed result.
REQ-012 SHALL have port res_ready, input, 1, the downstream accept signal.
REQ-013 SHALL have port ovf, output, 1, the sticky overflow flag (present only with FACT_OVF_EN).

Function
REQ-014 SHALL decode the counter register cnt (N_W bits) from wa: 10 -> cnt<=n_in; 01 -> cnt<=cnt-1, saturating at 0; 00/11 -> hold.
REQ-015 SHALL decode the accumulator acc (ACC_W bits) from wb: 00 -> acc<=1; 01 -> acc<=acc*m; 10/11 -> hold.
REQ-016 SHALL set multiplier operand m = cnt, except m = 1 when cnt==0, so that 0! = 1.
REQ-017 SHALL truncate the product to its low ACC_W bits on writeback.
REQ-018 SHALL drive z_out combinationally as (cnt <= 1), with no register delay.
REQ-019 SHALL execute the multiply and the decrement in the same cycle when wa=01 and wb=01, both using the pre-edge cnt.
REQ-020 SHALL detect the rising edge of done via a registered copy done_d.
REQ-021 SHALL, on done & !done_d, capture acc into res and set res_valid.
REQ-022 SHALL clear res_valid on res_valid & res_ready when no capture occurs in the same cycle.
REQ-023 SHALL give priority to a capture coinciding with an accept: load the new res, keep res_valid=1.
REQ-024 SHALL hold res stable while res_valid=1 and res_ready=0, apart from a new capture.
REQ-025 SHALL produce, for controller sequence load, (n-1 or 1) multiply cycles, then done: res = n! for n in 0..12 at ACC_W=32.

Reset
REQ-026 SHALL, while rst=0, force cnt=0, acc=1, done_d=0, res=0, res_valid=0, ovf=0; therefore z_out=1.
REQ-027 SHALL, on reset asserted mid-computation, abandon the computation with no res capture; the next result requires a fresh load.

Configuration
REQ-028 SHALL provide the macro FACT_OVF_EN to compile in overflow detection.
REQ-029 SHALL, with FACT_OVF_EN defined, set ovf when any product bit above ACC_W-1 is nonzero on a wb=01 cycle, hold ovf sticky, and clear it on wb=00.
REQ-030 SHALL, without FACT_OVF_EN, omit the ovf port and its logic entirely; all other behaviour is unchanged.

Structure
REQ-031 SHALL place WA_LOAD=2'b10, WA_DEC=2'b01, WA_HOLD=2'b00 and WB_INIT=2'b00, WB_MUL=2'b01, WB_HOLD=2'b10 in shared package fact_pkg, used by both controller and datapath.
REQ-032 SHALL implement the multiplier as sub-module fact_mul: combinational ACC_W x N_W to ACC_W+N_W bits, with m-substitution (REQ-016) kept in the parent.

Verification
REQ-033 SHALL cover n_in=5 driven by the controller: z_out first high after 4 multiply cycles, then res=120, res_valid=1 one cycle after done rises.
REQ-034 SHALL cover n_in=0 and n_in=1: z_out=1 immediately after load, then res=1 in both cases.
REQ-035 SHALL cover n_in=13 with FACT_OVF_EN defined: ovf=1 and res=13! mod 2^32 = 1932053504; a following load with n_in=3 clears ovf and yields res=6.
REQ-036 SHALL cover res_ready=0 for 5 cycles after capture: res_valid and res held; res_valid drops the cycle after res_ready=1.
REQ-037 SHALL cover a capture coinciding with an accept: new res loaded and res_valid stays 1.
REQ-038 SHALL cover rst pulsed low with n_in=7 mid-run: all outputs return to reset values immediately, and no capture occurs until the next done edge.
